// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: shares AD3/WE3/WD3 between pipeline
// writeback and buffered multicycle results, with a busy-register scoreboard.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_we,
    input  logic [ADDRESS_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]       alu_wd,
    output logic                        wb_stall,
    input  logic                        mc_valid,
    output logic                        mc_ready,
    input  logic [ADDRESS_WIDTH-1:0]    mc_rd,
    input  logic [DATA_WIDTH-1:0]       mc_wd,
    input  logic                        iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]    iss_rd,
    input  logic [ADDRESS_WIDTH-1:0]    dec_rs1,
    input  logic [ADDRESS_WIDTH-1:0]    dec_rs2,
    input  logic [ADDRESS_WIDTH-1:0]    dec_rd,
    output logic                        hazard_stall,
    output logic [ADDRESS_WIDTH-1:0]    AD3,
    output logic                        WE3,
    output logic [DATA_WIDTH-1:0]       WD3,
    output logic [2**ADDRESS_WIDTH-1:0] busy
);

    localparam int NREG  = 2**ADDRESS_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [ADDRESS_WIDTH-1:0] rd_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    wd_q [FIFO_DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [NREG-1:0]  busy_q, busy_d;

    logic                     fifo_ne;
    logic                     starved;
    logic                     push;
    logic                     pop;
    logic [ADDRESS_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0]    head_wd;

    assign fifo_ne = (count_q != '0);
    assign starved = (starve_q == STV_W'(STARVE_LIMIT));
    assign head_rd = rd_q[head_q];
    assign head_wd = wd_q[head_q];

    // Ready uses only the registered count, so a full FIFO never takes a pop credit.
    assign mc_ready = rst_n && (count_q < CNT_W'(FIFO_DEPTH));
    assign push     = mc_valid && mc_ready;
    assign pop      = rst_n && fifo_ne && (!alu_we || starved);
    assign wb_stall = rst_n && fifo_ne && alu_we && starved;

    assign hazard_stall = rst_n &&
                          (busy_q[dec_rs1] || busy_q[dec_rs2] || busy_q[dec_rd]);
    assign busy = busy_q;

    always_comb begin
        AD3 = '0;
        WD3 = '0;
        WE3 = 1'b0;
        if (rst_n) begin
            if (pop) begin
                AD3 = head_rd;
                WD3 = head_wd;
                WE3 = (head_rd != '0);
            end else begin
                AD3 = alu_rd;
                WD3 = alu_wd;
                WE3 = alu_we && (alu_rd != '0);
            end
        end
    end

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        starve_d = starve_q;
        busy_d   = busy_q;

        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop || !fifo_ne) begin
            starve_d = '0;
        end else if (alu_we) begin
            starve_d = starve_q + STV_W'(1);
        end

        // Issue is applied after commit so a same-cycle set beats the clear.
        if (pop) busy_d[head_rd] = 1'b0;
        if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q] <= mc_rd;
            wd_q[tail_q] <= mc_wd;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the integer register file. Shares the register file's single write port (AD3/WE3/WD3) between the in-order pipeline writeback and a long-latency multicycle unit (MUL/DIV/load). Buffers multicycle results in a small FIFO and tracks busy destination registers so decode can stall on RAW/WAW hazards. Sits between the writeback stage, the multicycle unit and the register file.

## Interface
- ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers)
- DATA_WIDTH, 32, write data width
- FIFO_DEPTH, 2, multicycle result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive ALU wins tolerated while FIFO non-empty

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, synchronous, active-low
- alu_we  in  1  pipeline writeback valid
- alu_rd  in  ADDRESS_WIDTH  pipeline destination
- alu_wd  in  DATA_WIDTH  pipeline result
- wb_stall  out  1  pipeline must hold writeback stage; alu_* re-presented next cycle
- mc_valid  in  1  multicycle result valid
- mc_ready  out  1  arbiter accepts result
- mc_rd  in  ADDRESS_WIDTH  multicycle destination
- mc_wd  in  DATA_WIDTH  multicycle result
- iss_valid  in  1  decode issues an op to the multicycle unit this cycle
- iss_rd  in  ADDRESS_WIDTH  destination of issued op
- dec_rs1, dec_rs2, dec_rd  in  ADDRESS_WIDTH each  decode-stage operands/destination
- hazard_stall  out  1  decode must stall
- AD3  out  ADDRESS_WIDTH  register file write address
- WE3  out  1  register file write enable
- WD3  out  DATA_WIDTH  register file write data
- busy  out  2**ADDRESS_WIDTH  scoreboard vector (bit 0 always 0)

## Operation
- State: FIFO (FIFO_DEPTH entries of {rd, wd}, head/tail pointers, count), busy vector, starvation counter starve_cnt (0..STARVE_LIMIT).
- Accept: mc handshake when mc_valid && mc_ready; mc_ready = (count < FIFO_DEPTH), from registered count only (no same-cycle pop credit).
- Grant, per cycle, combinational:
  - FIFO empty: ALU owns port; AD3=alu_rd, WD3=alu_wd, WE3=alu_we.
  - FIFO non-empty, alu_we=0: FIFO head writes (pop).
  - FIFO non-empty, alu_we=1, starve_cnt < STARVE_LIMIT: ALU wins; starve_cnt increments.
  - FIFO non-empty, alu_we=1, starve_cnt == STARVE_LIMIT: FIFO head wins, wb_stall=1, starve_cnt clears.
- starve_cnt clears on any FIFO pop or when FIFO empty.
- x0: WE3 forced 0 when granted AD3 == 0; an FIFO head with rd=0 still pops (write dropped).
- Scoreboard: iss_valid && iss_rd≠0 sets busy[iss_rd]; FIFO pop clears busy[head.rd]. Same register set and cleared in one cycle: set wins.
- hazard_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd] (registered busy; x0 never busy). Does not depend on iss_valid.
- No forwarding from FIFO; consumers wait until commit.

## Timing
- Reset (rst_n low at edge): FIFO empty, count 0, busy all 0, starve_cnt 0. While rst_n low: mc_ready=0, WE3=0, wb_stall=0, hazard_stall=0, AD3=0, WD3=0.
- mc accept in cycle N → earliest WE3 for that entry in cycle N+1; register file updated at end of N+1.
- busy set by issue in cycle N visible on hazard_stall in N+1; cleared by pop in cycle M, hazard_stall deasserts in M+1.
- FIFO full: mc_ready=0 next cycle; pop and push in the same cycle are illegal by construction (push requires count<DEPTH), so full → one pop → mc_ready=1 following cycle.
- Worst-case FIFO wait with continuous alu_we: STARVE_LIMIT+1 cycles per entry.
- Reset mid-operation drops buffered results and all busy bits; no WE3 during or in the cycle of reset.

## Test plan
- Reset: hold rst_n=0 with mc_valid=1, alu_we=1 → WE3=0, mc_ready=0; release → mc_ready=1, busy=0.
- Idle ALU: issue rd=5, then mc result {5, 0xDEADBEEF} accepted cycle N → WE3=1, AD3=5, WD3=0xDEADBEEF in N+1; busy[5] 1 from issue+1 until N+2.
- Starvation: FIFO holds one entry, alu_we=1 every cycle → ALU wins 4 cycles, cycle 5 FIFO writes with wb_stall=1, ALU write lands cycle 6.
- Backpressure: DEPTH=2, alu_we held 1, three mc results back-to-back → third sees mc_ready=0 until first pop, no result lost or reordered.
- Hazard: busy[7]=1, dec_rs2=7 → hazard_stall=1; dec_rd=7 (WAW) → 1; dec_rs1=0 → no stall from x0.
- x0 cases: iss_rd=0 leaves busy unchanged; mc result rd=0 pops with WE3=0; alu_rd=0 gives WE3=0.
